// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Widths, opcode values and the fetch FSM state type live here.
package instr_fetch_pkg;

  localparam int ADDR_W_D  = 4;
  localparam int INSTR_W_D = 16;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_LOAD = 3'b010;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with load, flush and valid-kill controls.
// Flush wins over load; load wins over kill; otherwise contents hold.
module ifid_reg
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_D,
  parameter int INSTR_W = INSTR_W_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               load,
  input  logic               kill,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [ADDR_W-1:0]  d_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= d_instr;
      pc    <= d_pc;
    end else if (kill) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, IDLE/RUN/HALTED control FSM and IF/ID.
// Redirect overrides stall, halt detection and start.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int         ADDR_W  = ADDR_W_D,
  parameter int         INSTR_W = INSTR_W_D,
  parameter logic [2:0] HALT_OP = OP_HALT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic               halted
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              fetch;
  logic              kill;
  logic              is_halt;

  assign is_halt = imem_instr[INSTR_W-1 -: 3] == HALT_OP;
  assign fetch   = (state == RUN) && !stall && !redirect_valid;
  assign kill    = (state == HALTED) && !stall && !redirect_valid;

  assign imem_addr = pc;
  assign halted    = (state == HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      if (state != IDLE) state <= RUN;
    end else begin
      unique case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          if (!stall) begin
            if (is_halt) state <= HALTED;
            else         pc    <= pc + 1'b1;
          end
        end
        HALTED: ;
        default: state <= IDLE;
      endcase
    end
  end

  ifid_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_ifid (
    .clk    (clk),
    .rst    (rst),
    .flush  (redirect_valid),
    .load   (fetch),
    .kill   (kill),
    .d_instr(imem_instr),
    .d_pc   (pc),
    .valid  (ifid_valid),
    .instr  (ifid_instr),
    .pc     (ifid_pc)
  );

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, PC and instruction-memory address width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width.
REQ-003 SHALL have parameter HALT_OP, default 3'b111, opcode (instr[15:13]) that stops fetch.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  in  1  begin fetching from the current PC.
REQ-007 SHALL have port stall  in  1  downstream hazard; freeze PC and IF/ID.
REQ-008 SHALL have port redirect_valid  in  1  branch/jump taken; load redirect_pc and flush.
REQ-009 SHALL have port redirect_pc  in  ADDR_W  target address.
REQ-010 SHALL have port imem_addr  out  ADDR_W  address to instruction memory; equals PC, combinational.
REQ-011 SHALL have port imem_instr  in  INSTR_W  instruction returned combinationally for imem_addr.
REQ-012 SHALL have port ifid_valid  out  1  IF/ID register holds a live instruction.
REQ-013 SHALL have port ifid_instr  out  INSTR_W  registered instruction for decode.
REQ-014 SHALL have port ifid_pc  out  ADDR_W  address ifid_instr was fetched from.
REQ-015 SHALL have port halted  out  1  high while FSM is in HALTED.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, HALTED.
REQ-017 IDLE: no capture, ifid_valid held 0; start=1 -> RUN at next edge; no fetch captured in the start cycle.
REQ-018 RUN, stall=0, redirect_valid=0: at edge ifid_instr<=imem_instr, ifid_pc<=PC, ifid_valid<=1, PC<=PC+1.
REQ-019 PC arithmetic SHALL be modulo 2^ADDR_W: PC=15 increments to 0, no flag.
REQ-020 RUN, captured opcode == HALT_OP: instruction captured with ifid_valid=1, PC NOT incremented, state -> HALTED.
REQ-021 RUN, stall=1, redirect_valid=0: PC, ifid_valid, ifid_instr, ifid_pc all hold.
REQ-022 redirect_valid=1 SHALL take priority over stall, halt detection and start: PC<=redirect_pc, ifid_valid<=0, ifid_instr<=0, ifid_pc<=0.
REQ-023 redirect in RUN or HALTED -> RUN; redirect in IDLE loads PC, stays IDLE.
REQ-024 HALTED, stall=0: ifid_valid<=0 at next edge; PC frozen; leaves only via redirect or reset.
REQ-025 HALTED, stall=1: IF/ID holds, so the HALT instruction remains presented.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 halted SHALL be registered state (state==HALTED), not decoded from imem_instr.
REQ-028 First instruction reaches IF/ID one edge after entering RUN; thereafter one per unstalled cycle.

Reset
REQ-029 rst=1 SHALL asynchronously force state=IDLE, PC=0, ifid_valid=0, ifid_instr=0, ifid_pc=0, halted=0.
REQ-030 Reset mid-operation (any state, stall or redirect active) SHALL yield exactly the REQ-029 values; first fetch after release requires a new start.

Structure
REQ-031 Package instr_fetch_pkg SHALL hold ADDR_W/INSTR_W defaults, opcode constants (ADD 3'b000, SUB 3'b001, LOAD 3'b010, HALT 3'b111), and the FSM state type.
REQ-032 IF/ID register with hold/flush SHALL be a sub-module ifid_reg; PC and FSM stay in instr_fetch.

Verification (imem: [0]=16'h00A0 ADD, [1]=16'h2C20 SUB, [2]=16'h5080 LOAD, [3]=16'hE000 HALT)
REQ-033 Reset, pulse start, no stall -> ifid sequence (pc,instr) (0,00A0),(1,2C20),(2,5080),(3,E000); then halted=1, ifid_valid=0, imem_addr stays 3.
REQ-034 stall=1 for 2 cycles while ifid_pc=1 -> ifid_instr stays 16'h2C20, imem_addr stays 2; release -> (2,5080) next edge.
REQ-035 redirect_valid=1, redirect_pc=0 with stall=1 at ifid_pc=2 -> next edge ifid_valid=0, PC=0; following edge (0,00A0).
REQ-036 imem all 16'h00A0, run from PC=14 -> ifid_pc 14,15,0,1 (wrap, no halt).
REQ-037 In HALTED, redirect_pc=1 -> RUN, halted=0, next capture (1,2C20); start pulses while RUN have no effect.
REQ-038 Assert rst mid-RUN asynchronously (between edges) -> all outputs immediately 0, state IDLE; no fetch until start.
